// File: rtl/shift_tx_ctrl_if.sv
// Bundle of requester handshakes, shift-register control and serial status
// shared by shift_tx_ctrl (slave side) and whatever drives the requesters.
`timescale 1ns/1ps
interface shift_tx_ctrl_if;
   logic        req0_valid;
   logic [15:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_data;
   logic        req1_ready;
   logic        sr_load;
   logic [15:0] sr_data;
   logic        sr_shift;
   logic        sr_out;
   logic        serial_out;
   logic        bit_valid;
   logic        grant_id;
   logic        busy;
   logic        done;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, sr_out,
      input  req0_ready, req1_ready, sr_load, sr_data, sr_shift,
             serial_out, bit_valid, grant_id, busy, done
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, sr_out,
      output req0_ready, req1_ready, sr_load, sr_data, sr_shift,
             serial_out, bit_valid, grant_id, busy, done
   );
endinterface

// File: rtl/shift_tx_ctrl.sv
// Two-requester round-robin front end that frames 16-bit words through an
// external shift register. Define SHIFT_TX_PARITY_EN to append an even-parity bit.
`timescale 1ns/1ps
module shift_tx_ctrl (
   input  logic           clk,
   input  logic           rst_n,
   shift_tx_ctrl_if.slave bus,
   output logic [2:0]     o_dbg_state
);
   // Handshake: a word moves when valid & ready are both high at a rising edge;
   // valid/data must stay stable until then, ready is only raised in IDLE.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
`ifdef SHIFT_TX_PARITY_EN
   localparam logic [2:0] ST_PAR   = 3'd3;
`endif
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [3:0] LAST_BIT = 4'd15;

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   logic [3:0]  r_bit_cnt;
   logic        r_prio;
   logic        r_grant;
   logic [15:0] r_word;
   logic        w_idle;
   logic        w_rdy0;
   logic        w_rdy1;
   logic        w_hs;
   logic [15:0] w_hs_word;
   logic        w_serial;
   logic        w_bit_valid;

   assign w_idle = (r_state == ST_IDLE);

   // r_prio names the requester that wins a tie; it points away from the last one served.
   always_comb begin
      w_rdy0 = 1'b0;
      w_rdy1 = 1'b0;
      if (rst_n && w_idle) begin
         if (bus.req0_valid && bus.req1_valid) begin
            w_rdy0 = ~r_prio;
            w_rdy1 = r_prio;
         end else begin
            w_rdy0 = bus.req0_valid;
            w_rdy1 = bus.req1_valid;
         end
      end
   end

   assign w_hs      = w_rdy0 | w_rdy1;
   assign w_hs_word = w_rdy1 ? bus.req1_data : bus.req0_data;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_hs) w_state_nxt = ST_LOAD;
         ST_LOAD:  w_state_nxt = ST_SHIFT;
         ST_SHIFT: begin
            if (r_bit_cnt == LAST_BIT) begin
`ifdef SHIFT_TX_PARITY_EN
               w_state_nxt = ST_PAR;
`else
               w_state_nxt = ST_DONE;
`endif
            end
         end
`ifdef SHIFT_TX_PARITY_EN
         ST_PAR:   w_state_nxt = ST_DONE;
`endif
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= 4'd0;
         r_prio    <= 1'b0;
         r_grant   <= 1'b0;
         r_word    <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_SHIFT) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end else begin
            r_bit_cnt <= 4'd0;
         end
         if (w_hs) begin
            r_word  <= w_hs_word;
            r_grant <= w_rdy1;
         end
         if (r_state == ST_DONE) begin
            r_prio <= ~r_grant;
         end
      end
   end

   always_comb begin
      w_serial    = 1'b0;
      w_bit_valid = 1'b0;
      if (r_state == ST_SHIFT) begin
         w_serial    = bus.sr_out;
         w_bit_valid = 1'b1;
      end
`ifdef SHIFT_TX_PARITY_EN
      else if (r_state == ST_PAR) begin
         w_serial    = ^r_word;
         w_bit_valid = 1'b1;
      end
`endif
   end

   assign bus.req0_ready = w_rdy0;
   assign bus.req1_ready = w_rdy1;
   assign bus.sr_load    = (r_state == ST_LOAD);
   assign bus.sr_shift   = (r_state == ST_SHIFT);
   assign bus.sr_data    = r_word;
   assign bus.serial_out = w_serial;
   assign bus.bit_valid  = w_bit_valid;
   assign bus.grant_id   = r_grant;
   assign bus.busy       = ~w_idle;
   assign bus.done       = (r_state == ST_DONE);
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl with a behavioural shift register and a
// scoreboard of accepted words checked against the serial stream at each done.
`timescale 1ns/1ps
module tb_shift_tx_ctrl;
`ifdef SHIFT_TX_PARITY_EN
   localparam int NBITS    = 17;
   localparam int DONE_LAT = 19;
`else
   localparam int NBITS    = 16;
   localparam int DONE_LAT = 18;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  dbg_state;
   logic [15:0] sr_reg = 16'h0000;
   logic [15:0] bits = 16'h0000;
   logic [16:0] exp_q[$];
   int          cyc_q[$];
   logic        gnt_log[$];
   logic [16:0] e_word;
   int          e_cyc;
   logic        m_prio = 1'b0;
   logic        m_exp_id;
   bit          rst_prev = 1'b0;
   bit          gap_chk = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          nbits = 0;
   int          hs_count = 0;
   int          last_done = -1;

   shift_tx_ctrl_if bus();

   shift_tx_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // external shift register: MSB goes out first
   assign bus.sr_out = sr_reg[15];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.sr_load) sr_reg <= bus.sr_data;
      else if (bus.sr_shift) sr_reg <= {sr_reg[14:0], 1'b0};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
         if (rst_prev) begin
            chk("rst_outputs", {9'd0, bus.sr_load, bus.sr_shift, bus.sr_data, bus.serial_out,
                                bus.bit_valid, bus.grant_id, bus.busy, bus.done}, 0);
            chk("rst_state", {29'd0, dbg_state}, 0);
         end
         exp_q.delete();
         cyc_q.delete();
         nbits = 0;
         bits = 16'h0000;
         m_prio = 1'b0;
         last_done = -1;
         rst_prev = 1'b1;
      end else begin
         rst_prev = 1'b0;
         chk("ready_excl", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
         if (bus.busy) chk("ready_busy", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
         if (!bus.bit_valid) chk("serial_idle", {31'd0, bus.serial_out}, 0);
         if (bus.req0_ready || bus.req1_ready) begin
            m_exp_id = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
            chk("grant_pick", {31'd0, bus.req1_ready}, {31'd0, m_exp_id});
            chk("ready_valid", {31'd0, bus.req1_ready ? bus.req1_valid : bus.req0_valid}, 1);
            if (gap_chk && last_done >= 0) chk("hs_gap", cyc - last_done, 1);
            exp_q.push_back({bus.req1_ready, bus.req1_ready ? bus.req1_data : bus.req0_data});
            cyc_q.push_back(cyc);
            gnt_log.push_back(bus.req1_ready);
            hs_count++;
         end
         if (bus.busy && exp_q.size() > 0) begin
            chk("hold_data", {16'd0, bus.sr_data}, {16'd0, exp_q[0][15:0]});
            chk("hold_grant", {31'd0, bus.grant_id}, {31'd0, exp_q[0][16]});
         end
         if (bus.sr_load && cyc_q.size() > 0) chk("load_lat", cyc - cyc_q[0], 1);
         if (bus.bit_valid) begin
            if (bus.sr_shift) begin
               chk("serial_eq_srout", {31'd0, bus.serial_out}, {31'd0, bus.sr_out});
               bits = {bits[14:0], bus.serial_out};
            end else if (exp_q.size() > 0) begin
               chk("parity_bit", {31'd0, bus.serial_out}, {31'd0, ^exp_q[0][15:0]});
            end
            nbits++;
         end
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e_word = exp_q.pop_front();
               e_cyc  = cyc_q.pop_front();
               chk("frame_bits", {16'd0, bits}, {16'd0, e_word[15:0]});
               chk("frame_grant", {31'd0, bus.grant_id}, {31'd0, e_word[16]});
               chk("frame_nbits", nbits, NBITS);
               chk("done_lat", cyc - e_cyc, DONE_LAT);
               m_prio = ~e_word[16];
            end
            last_done = cyc;
            nbits = 0;
         end
      end
   end

   task automatic send(input logic id, input logic [15:0] w);
      int n;
      n = 0;
      if (id) begin
         bus.req1_valid = 1'b1;
         bus.req1_data  = w;
      end else begin
         bus.req0_valid = 1'b1;
         bus.req0_data  = w;
      end
      do begin
         @(negedge clk);
         n++;
      end while (!(id ? bus.req1_ready : bus.req0_ready) && n < 200);
      chk("send_accept", {31'd0, id ? bus.req1_ready : bus.req0_ready}, 1);
      @(posedge clk);
      #1;
      if (id) bus.req1_valid = 1'b0;
      else bus.req0_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < 200);
      chk("wait_idle", {31'd0, bus.busy}, 0);
   endtask

   task automatic run_both(input int cnt, input logic [15:0] w0, input logic [15:0] w1);
      int start;
      int n;
      start = hs_count;
      n = 0;
      bus.req0_valid = 1'b1;
      bus.req0_data  = w0;
      bus.req1_valid = 1'b1;
      bus.req1_data  = w1;
      gap_chk = 1'b1;
      while (hs_count < start + cnt && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("both_handshakes", hs_count - start, cnt);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      gap_chk = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int g0;
      int h;
      logic        rid;
      logic [15:0] rword;
      bus.req0_valid = 1'b0;
      bus.req0_data  = 16'h0000;
      bus.req1_valid = 1'b0;
      bus.req1_data  = 16'h0000;
      do_reset(3);

      // single requester 0 frame
      send(1'b0, 16'h0101);
      wait_idle();

      // both requesters continuously: alternate from requester 0
      do_reset(2);
      g0 = gnt_log.size();
      run_both(4, 16'h1111, 16'hAAAA);
      wait_idle();
      for (int i = 0; i < 4; i++) chk("rr_order", {31'd0, gnt_log[g0 + i]}, i % 2);

      // one-cycle req1 pulse while busy is never served
      send(1'b0, 16'h5A3C);
      h = hs_count;
      repeat (3) @(posedge clk);
      #1;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 16'hFFFF;
      @(posedge clk);
      #1;
      bus.req1_valid = 1'b0;
      wait_idle();
      repeat (4) @(posedge clk);
      #1;
      chk("no_pulse_frame", hs_count, h);
      chk("idle_after_pulse", {31'd0, bus.busy}, 0);

      // reset during the 8th shift cycle discards the frame
      send(1'b1, 16'hC000);
      repeat (8) @(posedge clk);
      #1;
      chk("mid_shift_state", {29'd0, dbg_state}, 2);
      chk("mid_shift_bv", {31'd0, bus.bit_valid}, 1);
      rst_n = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_busy", {30'd0, bus.busy, bus.done}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      g0 = gnt_log.size();
      run_both(1, 16'h3C3C, 16'hC3C3);
      wait_idle();
      chk("post_rst_grant", {31'd0, gnt_log[g0]}, 0);

      // parity-sensitive words and a few random frames
      send(1'b0, 16'hE000);
      wait_idle();
      send(1'b1, 16'h001F);
      wait_idle();
      send(1'b0, 16'h8001);
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         rid   = 1'($urandom_range(0, 1));
         rword = 16'($urandom_range(0, 65535));
         send(rid, rword);
         wait_idle();
      end
      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
